// File: rtl/i2c_target_if.sv
// Register-file bus between the I2C target and fabric.
// The target drives the pointer and strobes; fabric returns read data.
interface i2c_target_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        output reg_rdata
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target with 8-bit register pointer, oversampled on the 25 MHz clock.
// Define I2C_TARGET_FILTER_EN to add a FILTER_LEN-sample glitch filter.
module i2c_target #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h42,
    parameter int         FILTER_LEN     = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         scl_in,
    input  logic         sda_in,
    output logic         sda_oe,
    output logic         busy,
    i2c_target_if.master bus
);

    if (FILTER_LEN < 1) begin : g_len_chk
        $error("FILTER_LEN must be at least 1");
    end

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_IGNORE,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_t;

    logic scl_s1, scl_s2, sda_s1, sda_s2;
    logic scl_l, sda_l, scl_d, sda_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
        end
    end

`ifdef I2C_TARGET_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [CW-1:0] scl_cnt, sda_cnt;
    logic          scl_f, sda_f;

    // A line only follows the sync output after FILTER_LEN differing samples
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_s2 == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
                scl_f   <= scl_s2;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_s2 == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
                sda_f   <= sda_s2;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    assign scl_l = scl_f;
    assign sda_l = sda_f;
`else
    assign scl_l = scl_s2;
    assign sda_l = sda_s2;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_l;
            sda_d <= sda_l;
        end
    end

    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_c, stop_c;

    assign scl_rise = scl_l & ~scl_d;
    assign scl_fall = ~scl_l & scl_d;
    assign sda_rise = sda_l & ~sda_d;
    assign sda_fall = ~sda_l & sda_d;
    assign start_c  = sda_fall & scl_l;
    assign stop_c   = sda_rise & scl_l;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       rw, ack_in, rd_ld, inc_pend;
    logic [7:0] reg_addr, reg_wdata;
    logic       reg_we, reg_re;

    assign bus.reg_addr  = reg_addr;
    assign bus.reg_wdata = reg_wdata;
    assign bus.reg_we    = reg_we;
    assign bus.reg_re    = reg_re;

    // bit_cnt counts SCL rises; a state acts on the fall that follows them
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rw        <= 1'b0;
            ack_in    <= 1'b1;
            rd_ld     <= 1'b0;
            inc_pend  <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            rd_ld  <= reg_re;
            if (inc_pend) begin
                reg_addr <= reg_addr + 8'd1;
                inc_pend <= 1'b0;
            end
            if (rd_ld && state == ST_RD) begin
                shift  <= bus.reg_rdata;
                sda_oe <= ~bus.reg_rdata[7];
            end
            if (start_c) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_c) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                if (scl_rise) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    ack_in  <= sda_l;
                    if (state != ST_RD)
                        shift <= {shift[6:0], sda_l};
                end
                if (scl_fall) begin
                    unique case (state)
                        ST_ADDR: if (bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            rw      <= shift[0];
                            if (shift[7:1] == DEVICE_ADDRESS) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                state  <= ST_ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IGNORE;
                            end
                        end
                        ST_ADDR_ACK: if (bit_cnt == 4'd1) begin
                            bit_cnt <= '0;
                            sda_oe  <= 1'b0;
                            if (rw) begin
                                reg_re <= 1'b1;
                                state  <= ST_RD;
                            end else begin
                                state  <= ST_PTR;
                            end
                        end
                        ST_PTR: if (bit_cnt == 4'd8) begin
                            bit_cnt  <= '0;
                            reg_addr <= shift;
                            sda_oe   <= 1'b1;
                            state    <= ST_PTR_ACK;
                        end
                        ST_WR: if (bit_cnt == 4'd8) begin
                            bit_cnt   <= '0;
                            reg_wdata <= shift;
                            reg_we    <= 1'b1;
                            inc_pend  <= 1'b1;
                            sda_oe    <= 1'b1;
                            state     <= ST_WR_ACK;
                        end
                        ST_PTR_ACK, ST_WR_ACK: if (bit_cnt == 4'd1) begin
                            bit_cnt <= '0;
                            sda_oe  <= 1'b0;
                            state   <= ST_WR;
                        end
                        ST_RD: if (bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            sda_oe  <= 1'b0;
                            state   <= ST_RD_ACK;
                        end else if (bit_cnt != 4'd0) begin
                            shift  <= {shift[6:0], 1'b0};
                            sda_oe <= ~shift[6];
                        end
                        ST_RD_ACK: if (bit_cnt == 4'd1) begin
                            bit_cnt  <= '0;
                            reg_addr <= reg_addr + 8'd1;
                            if (!ack_in) begin
                                reg_re <= 1'b1;
                                state  <= ST_RD;
                            end else begin
                                state  <= ST_WAIT_STOP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C controller and
// a register-file model returning ~addr on reads.
module tb_i2c_target;

    localparam int Q = 40;

    logic clock;
    logic reset_n;
    logic scl_o, sda_o;
    logic sda_oe, busy;
    logic sda_line;

    i2c_target_if bus ();

    assign sda_line = sda_o & ~sda_oe;

    i2c_target #(.DEVICE_ADDRESS(7'h42), .FILTER_LEN(3)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .scl_in (scl_o),
        .sda_in (sda_line),
        .sda_oe (sda_oe),
        .busy   (busy),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            bus.reg_rdata <= 8'h00;
        else if (bus.reg_re)
            bus.reg_rdata <= ~bus.reg_addr;
    end

    logic [7:0] we_a[$];
    logic [7:0] we_d[$];
    int re_n = 0;
    int both_n = 0;
    int oe_n = 0;
    int busy_n = 0;

    always @(negedge clock) begin
        if (bus.reg_we) begin
            we_a.push_back(bus.reg_addr);
            we_d.push_back(bus.reg_wdata);
        end
        if (bus.reg_re) re_n++;
        if (bus.reg_we && bus.reg_re) both_n++;
        if (sda_oe) oe_n++;
        if (busy) busy_n++;
    end

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clock);
    endtask

    task automatic bit_out(input logic b, input logic glitch);
        sda_o = b;
        wait_q();
        scl_o = 1'b1;
        repeat (Q / 2) @(negedge clock);
        if (glitch) begin
            scl_o = 1'b0;
            @(negedge clock);
            scl_o = 1'b1;
        end
        repeat (Q / 2) @(negedge clock);
        scl_o = 1'b0;
        wait_q();
    endtask

    task automatic bit_in(output logic b);
        sda_o = 1'b1;
        wait_q();
        scl_o = 1'b1;
        repeat (Q / 2) @(negedge clock);
        b = sda_line;
        repeat (Q / 2) @(negedge clock);
        scl_o = 1'b0;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, input int g,
                             output logic ack);
        for (int i = 7; i >= 0; i--)
            bit_out(d[i], i == g);
        bit_in(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(nack, 1'b0);
    endtask

    task automatic i2c_start();
        sda_o = 1'b1;
        wait_q();
        scl_o = 1'b1;
        wait_q();
        sda_o = 1'b0;
        wait_q();
        scl_o = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        sda_o = 1'b0;
        wait_q();
        scl_o = 1'b1;
        wait_q();
        sda_o = 1'b1;
        wait_q();
        wait_q();
    endtask

`ifdef I2C_TARGET_FILTER_EN
    localparam logic [7:0] T6_EXP = 8'hA5;
`else
    localparam logic [7:0] T6_EXP = 8'hD2;
`endif

    initial begin
        logic a0, a1, a2, a3;
        logic [7:0] d0, d1, b84;
        int wb, rb, ob, bb;

        reset_n = 1'b0;
        scl_o = 1'b1;
        sda_o = 1'b1;
        repeat (5) @(negedge clock);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_addr", bus.reg_addr, 0);
        check("rst_wdata", bus.reg_wdata, 0);
        check("rst_we", bus.reg_we, 0);
        check("rst_re", bus.reg_re, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);

        // 1: pointer 0x10, two writes
        wb = we_a.size();
        bb = busy_n;
        i2c_start();
        send_byte(8'h84, -1, a0);
        send_byte(8'h10, -1, a1);
        send_byte(8'hA5, -1, a2);
        send_byte(8'h3C, -1, a3);
        check("t1_busy_mid", busy, 1);
        i2c_stop();
        check("t1_ack0", a0, 0);
        check("t1_ack1", a1, 0);
        check("t1_ack2", a2, 0);
        check("t1_ack3", a3, 0);
        check("t1_we_cnt", we_a.size() - wb, 2);
        if (we_a.size() - wb == 2) begin
            check("t1_we0_a", we_a[wb], 8'h10);
            check("t1_we0_d", we_d[wb], 8'hA5);
            check("t1_we1_a", we_a[wb+1], 8'h11);
            check("t1_we1_d", we_d[wb+1], 8'h3C);
        end
        check("t1_busy_seen", busy_n > bb, 1);
        check("t1_busy_end", busy, 0);
        check("t1_addr_end", bus.reg_addr, 8'h12);

        // 2: pointer 0x20, repeated start, read two bytes
        wb = we_a.size();
        rb = re_n;
        i2c_start();
        send_byte(8'h84, -1, a0);
        send_byte(8'h20, -1, a1);
        i2c_start();
        send_byte(8'h85, -1, a2);
        recv_byte(d0, 1'b0);
        recv_byte(d1, 1'b1);
        check("t2_oe_nack", sda_oe, 0);
        check("t2_busy_mid", busy, 1);
        i2c_stop();
        check("t2_ack0", a0, 0);
        check("t2_ack1", a1, 0);
        check("t2_ack2", a2, 0);
        check("t2_rd0", d0, 8'hDF);
        check("t2_rd1", d1, 8'hDE);
        check("t2_re_cnt", re_n - rb, 2);
        check("t2_we_cnt", we_a.size() - wb, 0);
        check("t2_addr_end", bus.reg_addr, 8'h22);
        check("t2_busy_end", busy, 0);

        // 3: foreign address
        wb = we_a.size();
        ob = oe_n;
        bb = busy_n;
        i2c_start();
        send_byte(8'hA0, -1, a0);
        send_byte(8'h55, -1, a1);
        i2c_stop();
        check("t3_nack0", a0, 1);
        check("t3_nack1", a1, 1);
        check("t3_oe_cnt", oe_n - ob, 0);
        check("t3_we_cnt", we_a.size() - wb, 0);
        check("t3_busy_cnt", busy_n - bb, 0);

        // 4: pointer wrap
        wb = we_a.size();
        i2c_start();
        send_byte(8'h84, -1, a0);
        send_byte(8'hFF, -1, a1);
        send_byte(8'h11, -1, a2);
        send_byte(8'h22, -1, a3);
        i2c_stop();
        check("t4_acks", {a0, a1, a2, a3}, 0);
        check("t4_we_cnt", we_a.size() - wb, 2);
        if (we_a.size() - wb == 2) begin
            check("t4_we0_a", we_a[wb], 8'hFF);
            check("t4_we0_d", we_d[wb], 8'h11);
            check("t4_we1_a", we_a[wb+1], 8'h00);
            check("t4_we1_d", we_d[wb+1], 8'h22);
        end
        check("t4_addr_end", bus.reg_addr, 8'h01);

        // 5: reset during address ACK
        b84 = 8'h84;
        i2c_start();
        for (int i = 7; i >= 0; i--)
            bit_out(b84[i], 1'b0);
        sda_o = 1'b1;
        wait_q();
        check("t5_oe_ack", sda_oe, 1);
        #7 reset_n = 1'b0;
        #1;
        check("t5_oe_async", sda_oe, 0);
        check("t5_addr_rst", bus.reg_addr, 0);
        check("t5_busy_rst", busy, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        wb = we_a.size();
        ob = oe_n;
        scl_o = 1'b1;
        wait_q();
        scl_o = 1'b0;
        wait_q();
        send_byte(8'h10, -1, a0);
        send_byte(8'hA5, -1, a1);
        check("t5_nack0", a0, 1);
        check("t5_nack1", a1, 1);
        check("t5_oe_cnt", oe_n - ob, 0);
        check("t5_we_cnt", we_a.size() - wb, 0);
        i2c_stop();
        check("t5_busy_end", busy, 0);

        // 6: one-cycle SCL glitch during the MSB of a data byte
        wb = we_a.size();
        i2c_start();
        send_byte(8'h84, -1, a0);
        send_byte(8'h30, -1, a1);
        send_byte(8'hA5, 7, a2);
        i2c_stop();
        check("t6_acks", {a0, a1}, 0);
        check("t6_we_cnt", we_a.size() - wb, 1);
        if (we_a.size() - wb == 1) begin
            check("t6_we_a", we_a[wb], 8'h30);
            check("t6_we_d", we_d[wb], T6_EXP);
        end
        check("t6_busy_end", busy, 0);

        check("we_re_overlap", both_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
